// File: rtl/traffic_light.sv
// Highway / farm-road intersection controller. The highway stays green by default.
// A latched farm-road request runs one yellow/farm-green/yellow sequence once
// the highway has had its minimum green.
module traffic_light #(
  parameter int HWY_MIN_GREEN     = 4,
  parameter int YELLOW_CYCLES     = 3,
  parameter int FARM_GREEN_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       C,
  output logic [2:0] light_highway,
  output logic [2:0] light_farm
);

  // state | meaning
  // HG    | highway green, farm red (default, waits for req and min green)
  // HY    | highway yellow, farm red
  // FG    | highway red, farm green (fixed length)
  // FY    | highway red, farm yellow
  typedef enum logic [1:0] {HG, HY, FG, FY} state_t;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  localparam int MAX_A = (HWY_MIN_GREEN > YELLOW_CYCLES) ? HWY_MIN_GREEN : YELLOW_CYCLES;
  localparam int MAX_P = (MAX_A > FARM_GREEN_CYCLES) ? MAX_A : FARM_GREEN_CYCLES;
  localparam int TW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [TW-1:0] HG_LAST = TW'(HWY_MIN_GREEN - 1);
  localparam logic [TW-1:0] Y_LAST  = TW'(YELLOW_CYCLES - 1);
  localparam logic [TW-1:0] FG_LAST = TW'(FARM_GREEN_CYCLES - 1);

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   timer;
  logic            req;

  always_comb begin
    state_nxt = state;
    case (state)
      HG: if (req && timer == HG_LAST) state_nxt = HY;
      HY: if (timer == Y_LAST)         state_nxt = FG;
      FG: if (timer == FG_LAST)        state_nxt = FY;
      FY: if (timer == Y_LAST)         state_nxt = HG;
      default:                         state_nxt = HG;
    endcase
  end

  // Lamps are registered from the next state so they change in the same
  // cycle as the state register without any decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HG;
      timer         <= '0;
      req           <= 1'b0;
      light_highway <= LAMP_GREEN;
      light_farm    <= LAMP_RED;
    end else begin
      state <= state_nxt;

      if (state_nxt != state)
        timer <= '0;
      else if (!(state == HG && timer == HG_LAST))
        timer <= timer + 1'b1;

      // A new request on the serving edge wins, scheduling another farm cycle.
      if (C)
        req <= 1'b1;
      else if (state == HY && state_nxt == FG)
        req <= 1'b0;

      case (state_nxt)
        HG: begin light_highway <= LAMP_GREEN;  light_farm <= LAMP_RED;    end
        HY: begin light_highway <= LAMP_YELLOW; light_farm <= LAMP_RED;    end
        FG: begin light_highway <= LAMP_RED;    light_farm <= LAMP_GREEN;  end
        FY: begin light_highway <= LAMP_RED;    light_farm <= LAMP_YELLOW; end
        default: begin light_highway <= LAMP_GREEN; light_farm <= LAMP_RED; end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light.sv
// Directed bench for traffic_light with default parameters; expected lamp
// sequences are written out per edge count after reset release.
module tb_traffic_light;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       clk;
  logic       rst_n;
  logic       C;
  logic [2:0] light_highway;
  logic [2:0] light_farm;

  int tests_run;
  int tests_failed;

  traffic_light dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .C            (C),
    .light_highway(light_highway),
    .light_farm   (light_farm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    C     = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Expected lamps for one request taken with HY entered at edge hy_edge.
  task automatic exp_seq(input int k, input int hy_edge,
                         output logic [2:0] eh, output logic [2:0] ef);
    if (k < hy_edge)           begin eh = G; ef = R; end
    else if (k < hy_edge + 3)  begin eh = Y; ef = R; end
    else if (k < hy_edge + 9)  begin eh = R; ef = G; end
    else if (k < hy_edge + 12) begin eh = R; ef = Y; end
    else                       begin eh = G; ef = R; end
  endtask

  task automatic test_reset();
    C     = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (light_highway !== G || light_farm !== R) begin
        tests_failed++;
        $display("FAIL reset_hold cyc=%0d: got hwy=%b farm=%b, want hwy=%b farm=%b",
                 i, light_highway, light_farm, G, R);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      tests_run++;
      if (light_highway !== G || light_farm !== R || dut.req !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle k=%0d: got hwy=%b farm=%b req=%b, want hwy=%b farm=%b req=0",
                 k, light_highway, light_farm, dut.req, G, R);
      end
    end
  endtask

  task automatic test_short_pulse();
    logic [2:0] eh, ef;
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      C = (k == 3 || k == 4);
      tick();
      exp_seq(k, 4, eh, ef);
      tests_run++;
      if (light_highway !== eh || light_farm !== ef) begin
        tests_failed++;
        $display("FAIL short_pulse k=%0d: got hwy=%b farm=%b, want hwy=%b farm=%b",
                 k, light_highway, light_farm, eh, ef);
      end
    end
    C = 1'b0;
    tests_run++;
    if (dut.req !== 1'b0) begin
      tests_failed++;
      $display("FAIL short_pulse_req: got req=%b, want 0", dut.req);
    end
  endtask

  task automatic test_min_green();
    logic [2:0] eh, ef;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      C = (k == 1);
      tick();
      exp_seq(k, 4, eh, ef);
      tests_run++;
      if (light_highway !== eh || light_farm !== ef) begin
        tests_failed++;
        $display("FAIL min_green k=%0d: got hwy=%b farm=%b, want hwy=%b farm=%b",
                 k, light_highway, light_farm, eh, ef);
      end
    end
    C = 1'b0;
  endtask

  task automatic test_req_in_farm();
    logic [2:0] eh, ef;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      C = (k == 1 || k == 9);
      tick();
      if (k < 16) exp_seq(k, 4, eh, ef);
      else        exp_seq(k, 20, eh, ef);
      tests_run++;
      if (light_highway !== eh || light_farm !== ef) begin
        tests_failed++;
        $display("FAIL req_in_farm k=%0d: got hwy=%b farm=%b, want hwy=%b farm=%b",
                 k, light_highway, light_farm, eh, ef);
      end
    end
    C = 1'b0;
    tests_run++;
    if (dut.req !== 1'b0) begin
      tests_failed++;
      $display("FAIL req_in_farm_req: got req=%b, want 0", dut.req);
    end
  endtask

  task automatic test_c_held();
    logic [2:0] eh, ef;
    int m;
    do_reset();
    C = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k < 4) begin
        eh = G; ef = R;
      end else begin
        m = (k - 4) % 16;
        if (m < 3)       begin eh = Y; ef = R; end
        else if (m < 9)  begin eh = R; ef = G; end
        else if (m < 12) begin eh = R; ef = Y; end
        else             begin eh = G; ef = R; end
      end
      tests_run++;
      if (light_highway !== eh || light_farm !== ef) begin
        tests_failed++;
        $display("FAIL c_held k=%0d: got hwy=%b farm=%b, want hwy=%b farm=%b",
                 k, light_highway, light_farm, eh, ef);
      end
      tests_run++;
      if (!(light_highway === R || light_farm === R) ||
          !(light_highway inside {G, Y, R}) || !(light_farm inside {G, Y, R})) begin
        tests_failed++;
        $display("FAIL safety k=%0d: got hwy=%b farm=%b, want one-hot lamps with one road 100",
                 k, light_highway, light_farm);
      end
    end
    C = 1'b0;
  endtask

  task automatic test_async_reset_fg();
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      C = (k == 1 || k == 8);
      tick();
    end
    C = 1'b0;
    tests_run++;
    if (light_highway !== R || light_farm !== G || dut.req !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_fg: got hwy=%b farm=%b req=%b, want hwy=%b farm=%b req=1",
               light_highway, light_farm, dut.req, R, G);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (light_highway !== G || light_farm !== R || dut.req !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got hwy=%b farm=%b req=%b, want hwy=%b farm=%b req=0",
               light_highway, light_farm, dut.req, G, R);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      tests_run++;
      if (light_highway !== G || light_farm !== R) begin
        tests_failed++;
        $display("FAIL after_async_reset k=%0d: got hwy=%b farm=%b, want hwy=%b farm=%b",
                 k, light_highway, light_farm, G, R);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    C            = 1'b0;
    #3;
    test_reset();
    test_short_pulse();
    test_min_green();
    test_req_in_farm();
    test_c_held();
    test_async_reset_fg();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
